// File: rtl/cycle_count_reporter.sv
// Snapshots the cycle count on request and streams it as 8 uppercase hex ASCII
// digits plus LINE_END. Define CYCLE_REPORT_PREFIX_EN to prepend "CYC=".
module cycle_count_reporter #(
    parameter logic [7:0] LINE_END = 8'h0A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        report,
    input  logic [31:0] count,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady,
    output logic        busy,
    output logic        overrun
);
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned BYTE_W = 8;

`ifdef CYCLE_REPORT_PREFIX_EN
    localparam int unsigned PIDX_W = 2;
    typedef enum logic [1:0] { IDLE, PREFIX, HEX, TERM } state_t;
`else
    typedef enum logic [1:0] { IDLE, HEX, TERM } state_t;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   snap_q, snap_d;
    logic [IDX_W-1:0]   idx_q, idx_d, idx_dec;
    logic [BYTE_W-1:0]  data_d;
    logic               valid_d, busy_d, overrun_d;
    logic               xfer;
`ifdef CYCLE_REPORT_PREFIX_EN
    logic [PIDX_W-1:0]  pidx_q, pidx_d, pidx_inc;
`endif

    function automatic logic [BYTE_W-1:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + 8'(n);
        else           return 8'h37 + 8'(n);
    endfunction

`ifdef CYCLE_REPORT_PREFIX_EN
    // "CYC=" sent ahead of the digits
    function automatic logic [BYTE_W-1:0] prefix_byte(input logic [1:0] p);
        case (p)
            2'd0:    return 8'h43;
            2'd1:    return 8'h59;
            2'd2:    return 8'h43;
            default: return 8'h3D;
        endcase
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            txData  <= 8'h00;
            txValid <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
`ifdef CYCLE_REPORT_PREFIX_EN
            pidx_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            txData  <= data_d;
            txValid <= valid_d;
            busy    <= busy_d;
            overrun <= overrun_d;
`ifdef CYCLE_REPORT_PREFIX_EN
            pidx_q  <= pidx_d;
`endif
        end
    end

    // Next-state and next-output values; every output is loaded from here.
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        idx_d     = idx_q;
        data_d    = txData;
        valid_d   = txValid;
        busy_d    = busy;
        overrun_d = overrun;
        xfer      = txValid && txReady;
        idx_dec   = IDX_W'(idx_q - 3'd1);
`ifdef CYCLE_REPORT_PREFIX_EN
        pidx_d    = pidx_q;
        pidx_inc  = PIDX_W'(pidx_q + 2'd1);
`endif

        if (report && busy) overrun_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (report) begin
                    snap_d  = count;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    idx_d   = 3'd7;
`ifdef CYCLE_REPORT_PREFIX_EN
                    state_d = PREFIX;
                    pidx_d  = 2'd0;
                    data_d  = prefix_byte(2'd0);
`else
                    state_d = HEX;
                    data_d  = hex_ascii(count[31:28]);
`endif
                end
            end
`ifdef CYCLE_REPORT_PREFIX_EN
            PREFIX: begin
                if (xfer) begin
                    if (pidx_q == 2'd3) begin
                        state_d = HEX;
                        data_d  = hex_ascii(snap_q[31:28]);
                    end else begin
                        pidx_d  = pidx_inc;
                        data_d  = prefix_byte(pidx_inc);
                    end
                end
            end
`endif
            HEX: begin
                if (xfer) begin
                    if (idx_q == 3'd0) begin
                        state_d = TERM;
                        data_d  = LINE_END;
                    end else begin
                        idx_d   = idx_dec;
                        data_d  = hex_ascii(snap_q[{idx_dec, 2'b00} +: 4]);
                    end
                end
            end
            TERM: begin
                if (xfer) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    data_d  = 8'h00;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cycle_count_reporter.sv
// Bench for cycle_count_reporter: random counts and backpressure against a
// reference that formats the snapshot as text bytes.
module tb_cycle_count_reporter;

    logic        clk = 1'b0;
    logic        rst;
    logic        report;
    logic [31:0] count;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic        busy;
    logic        overrun;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_q[$];

    cycle_count_reporter dut (
        .clk     (clk),
        .rst     (rst),
        .report  (report),
        .count   (count),
        .txData  (txData),
        .txValid (txValid),
        .txReady (txReady),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: the text a host should see for a given count.
    task automatic build_frame(input logic [31:0] cnt);
        int d;
        exp_q.delete();
`ifdef CYCLE_REPORT_PREFIX_EN
        exp_q.push_back(8'h43);
        exp_q.push_back(8'h59);
        exp_q.push_back(8'h43);
        exp_q.push_back(8'h3D);
`endif
        for (int i = 7; i >= 0; i--) begin
            d = int'((cnt >> (4 * i)) & 32'hF);
            exp_q.push_back(d < 10 ? 8'(48 + d) : 8'(55 + d));
        end
        exp_q.push_back(8'h0A);
    endtask

    // mode 0: ready always 1; 1: ready pattern 1,0,0,1; 2: random ready.
    // A report is injected (with ready forced) while byte inj_a or inj_b is presented.
    task automatic run_frame(input logic [31:0] cnt, input int mode,
                             input int inj_a, input int inj_b, input bit inc_count);
        int idx;
        int cyc;
        bit r;
        bit rep;
        build_frame(cnt);
        count   = cnt;
        report  = 1'b1;
        txReady = 1'b0;
        @(negedge clk);
        report = 1'b0;
        check("first_busy", 32'(busy), 32'd1);
        idx = 0;
        cyc = 0;
        while (idx < exp_q.size() && cyc < 200) begin
            check("valid_held", 32'(txValid), 32'd1);
            check("byte", 32'(txData), 32'(exp_q[idx]));
            if (mode == 0)      r = 1'b1;
            else if (mode == 1) r = (cyc % 4 == 0) || (cyc % 4 == 3);
            else                r = ($urandom_range(0, 99) < 60);
            rep = 1'b0;
            if (idx == inj_a || idx == inj_b) begin
                r   = 1'b1;
                rep = 1'b1;
            end
            txReady = r;
            report  = rep;
            if (inc_count) count = count + 32'd1;
            else           count = $urandom();
            @(negedge clk);
            report = 1'b0;
            if (r) idx++;
            cyc++;
        end
        check("frame_len", 32'(idx), 32'(exp_q.size()));
        check("end_valid", 32'(txValid), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        if (mode == 0) check("frame_cycles", 32'(cyc), 32'(exp_q.size()));
        txReady = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        report  = 1'b0;
        txReady = 1'b0;
        count   = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(txValid), 32'd0);
        check("rst_data", 32'(txData), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_frame(32'hDEADBEEF, 0, -1, -1, 1'b0);
        run_frame(32'h00000009, 0, -1, -1, 1'b1);
        run_frame(32'hDEADBEEF, 1, -1, -1, 1'b0);
        for (int k = 0; k < 4; k++) run_frame($urandom(), 2, -1, -1, 1'b0);
        check("no_overrun", 32'(overrun), 32'd0);

        // Reports during the 4th byte and the final transfer are dropped.
        build_frame(32'h0);
        run_frame($urandom(), 0, 3, exp_q.size() - 1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_second_frame", 32'(txValid), 32'd0);
            check("overrun_sticky", 32'(overrun), 32'd1);
        end

        // Reset after three transfers aborts the frame.
        count  = $urandom();
        report = 1'b1;
        @(negedge clk);
        report  = 1'b0;
        txReady = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", 32'(txValid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_overrun", 32'(overrun), 32'd0);
        check("abort_data", 32'(txData), 32'h00);
        @(negedge clk);
        check("abort_quiet", 32'(txValid), 32'd0);
        txReady = 1'b0;

        run_frame(32'h12345678, 0, -1, -1, 1'b0);
        run_frame(32'h0000ABCD, 0, -1, -1, 1'b0);
        check("final_overrun", 32'(overrun), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cycle_count_reporter.md
# cycle_count_reporter

Downstream consumer of the cycle counter's 32-bit `count` output. When the benchmark harness pulses `report`, this block snapshots `count` and streams it as 8 uppercase ASCII hex digits plus a line terminator over a byte-wide valid/ready interface. That interface feeds the UART transmitter, so benchmark cycle counts reach the host console with no software formatting.

## Interface
- `LINE_END`, default 8'h0A: terminator byte sent after the last hex digit.

- `clk` input 1: single clock; all state updates on posedge.
- `rst` input 1: reset, synchronous, active-high.
- `report` input 1: single-cycle request to snapshot and send `count`; only sampled while `busy`=0.
- `count` input 32: live cycle count from the cycle counter.
- `txData` output 8: current byte; must hold stable while `txValid`=1 and `txReady`=0.
- `txValid` output 1: `txData` holds a valid byte.
- `txReady` input 1: sink accepts the byte; a transfer occurs on a posedge where `txValid`&&`txReady`.
- `busy` output 1: snapshot held, frame not yet fully sent.
- `overrun` output 1: sticky; set when `report`=1 arrives while `busy`=1; cleared only by `rst`.

## Operation
- Reset values: `txValid`=0, `txData`=8'h00, `busy`=0, `overrun`=0, state IDLE, snapshot register 0, digit index 0.
- States: IDLE, PREFIX (only with macro), HEX, TERM.
- IDLE:
  - if `report`=1, latch `count` into the snapshot and set `busy`=1.
  - Go to PREFIX (macro defined) or HEX with digit index 7.
- HEX:
  - `txData` = ASCII of snapshot nibble [4*idx+3:4*idx].
  - Nibble 0–9 maps to 8'h30–8'h39; A–F maps to 8'h41–8'h46.
  - On each transfer, decrement idx. The transfer at idx 0 moves to TERM.
- TERM: `txData`=`LINE_END`. Its transfer returns to IDLE and clears `busy`.
- Frame order is MSB nibble first, fixed length. Leading zeros are always sent.
- The snapshot is immune to `count` changes for the whole frame.
- `report` while `busy`=1 is dropped, with no queueing, and sets `overrun`. This includes the cycle of the final transfer.
- `rst` mid-frame aborts immediately: no further bytes, all outputs return to reset values.

## Timing
- `report` sampled at edge N: `txValid`=1 with the first byte from cycle N+1.
- With `txReady` held at 1, one byte transfers per cycle.
- Without prefix: frame occupies cycles N+1..N+9, and `busy` falls at cycle N+10.
- The same transfer edge that completes the terminator sets `txValid`=0 and `busy`=0.
- The earliest accepted next `report` is sampled one cycle after `busy` falls.
- `txValid` never drops while in PREFIX/HEX/TERM, regardless of `txReady`.
- Backpressure stalls indefinitely with `txData` unchanged.
- `txData` is registered. There is no combinational path from `txReady` or `report` to any output.

## Configuration
- `CYCLE_REPORT_PREFIX_EN` defined:
  - PREFIX state is compiled in.
  - Before the digits, the frame sends 8'h43, 8'h59, 8'h43, 8'h3D ("CYC=").
  - Frame is 13 bytes; `busy` falls at N+14 with `txReady`=1.
- Not defined: PREFIX state and its index logic are absent. Frame is 9 bytes.

## Test plan
- `count`=32'hDEADBEEF, pulse `report`, `txReady`=1: bytes 44,45,41,44,42,45,45,46,0A on consecutive cycles; `busy` low after 9 transfers.
- `count`=32'h00000009: bytes 30×7, 39, 0A. `count` incrementing during the frame does not alter the bytes.
- `txReady` toggling 1,0,0,1 pattern: `txData`/`txValid` held during the 0 cycles; byte sequence and count identical to the unstalled case.
- `report` pulsed again during the 4th byte and during the final-transfer cycle: no second frame, `overrun`=1 and stays 1 until `rst`.
- `rst`=1 after 3 transfers: next cycle `txValid`=0, `busy`=0, `overrun`=0. A following `report` with `count`=32'h12345678 sends a clean 31..38,0A frame.
- With `CYCLE_REPORT_PREFIX_EN`, `count`=32'h0000ABCD: bytes 43,59,43,3D,30,30,30,30,41,42,43,44,0A.
